nr_convergence_monitor: RTL and testbench

- Downstream consumer of the 3-variable Newton-Raphson/Broyden solver.
- On each solver strobe, takes the iterate x0..x2 and the residuals f0..f2 (IEEE-754 single), and forms the residual infinity-norm max|f_i|.
- Decides converged / iteration-limit / non-finite fault, latches the final iterate, and raises halt so the solver stops.
- Uses no FP arithmetic unit: all magnitude comparison is integer compare on sign-cleared bit patterns.

---
 rtl/nr_pkg.sv | 29 ++
 rtl/fp_mag_max3.sv | 24 ++
 rtl/nr_convergence_monitor.sv | 114 +++++++++++
 tb/tb_nr_convergence_monitor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/nr_pkg.sv
// Shared definitions for the Newton-Raphson convergence monitor:
// status codes, FSM states, and IEEE-754 single-precision field helpers.
package nr_pkg;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_CONV    = 2'b01;
  localparam logic [1:0] ST_MAXITER = 2'b10;
  localparam logic [1:0] ST_FAULT   = 2'b11;

  localparam int         FP_EXP_MSB = 30;
  localparam int         FP_EXP_LSB = 23;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mon_state_t;

  // Sign-cleared bit pattern; orders non-NaN floats by magnitude as an unsigned integer.
  function automatic logic [30:0] fp_mag(input logic [31:0] x);
    return x[30:0];
  endfunction

  function automatic logic fp_nonfinite(input logic [31:0] x);
    return x[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX;
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] x);
    return fp_nonfinite(x) && (x[FP_EXP_LSB-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_mag_max3.sv
// Largest magnitude of three floats (integer compare on sign-cleared bits)
// plus a flag raised when any input is Inf or NaN.
module fp_mag_max3
  import nr_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [30:0] mag_max,
  output logic        nonfinite
);

  logic [30:0] ma, mb, mc, mab;

  always_comb begin
    ma        = fp_mag(a);
    mb        = fp_mag(b);
    mc        = fp_mag(c);
    mab       = (ma >= mb) ? ma : mb;
    mag_max   = (mab >= mc) ? mab : mc;
    nonfinite = fp_nonfinite(a) | fp_nonfinite(b) | fp_nonfinite(c);
  end

endmodule

// File: rtl/nr_convergence_monitor.sv
// Watches solver strobes, forms max|f_i|, and decides converged / iteration
// limit / non-finite fault through a two-stage pipeline; halts the solver on a decision.
module nr_convergence_monitor
  import nr_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_cycles,
  input  logic [W-1:0]  tol,
  input  logic          f_stb,
  input  logic [W-1:0]  x0,
  input  logic [W-1:0]  x1,
  input  logic [W-1:0]  x2,
  input  logic [W-1:0]  f0,
  input  logic [W-1:0]  f1,
  input  logic [W-1:0]  f2,
  output logic          busy,
  output logic          done,
  output logic          halt,
  output logic [1:0]    status,
  output logic [6:0]    iter_cnt,
  output logic [W-1:0]  res_norm,
  output logic [W-1:0]  res_x0,
  output logic [W-1:0]  res_x1,
  output logic [W-1:0]  res_x2
);

  mon_state_t    state_q, state_d;
  logic [W-1:0]  tol_q;
  logic [CW-1:0] ncyc_q;
  logic [6:0]    limit;
  logic [30:0]   f_mag_max, s1_m;
  logic          f_nonfin, s1_fault, s1_vld;
  logic          accept, conv, decide;
  logic [1:0]    dec_status;

  fp_mag_max3 u_fmax (
    .a         (f0),
    .b         (f1),
    .c         (f2),
    .mag_max   (f_mag_max),
    .nonfinite (f_nonfin)
  );

  always_comb begin
    limit  = (ncyc_q == '0) ? 7'd64 : 7'(ncyc_q);
    conv   = (s1_m <= fp_mag(tol_q)) && !fp_is_nan(tol_q);
    decide = s1_vld && (s1_fault || conv || (iter_cnt == limit));
    // The deciding cycle refuses a new strobe so nothing lands after the result.
    accept = f_stb && !start && (state_q == S_RUN) && !decide;
    dec_status = s1_fault ? ST_FAULT : (conv ? ST_CONV : ST_MAXITER);
  end

  always_comb begin
    state_d = state_q;
    if (start) state_d = S_RUN;
    else if (state_q == S_RUN && decide) state_d = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tol_q    <= '0;
      ncyc_q   <= '0;
      s1_vld   <= 1'b0;
      s1_m     <= '0;
      s1_fault <= 1'b0;
      iter_cnt <= '0;
      status   <= ST_NONE;
      done     <= 1'b0;
      res_norm <= '0;
      res_x0   <= '0;
      res_x1   <= '0;
      res_x2   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        tol_q    <= tol;
        ncyc_q   <= num_cycles;
        s1_vld   <= 1'b0;
        iter_cnt <= '0;
        status   <= ST_NONE;
        done     <= 1'b0;
        res_norm <= '0;
        res_x0   <= '0;
        res_x1   <= '0;
        res_x2   <= '0;
      end else begin
        s1_vld <= accept;
        if (accept) begin
          res_x0   <= x0;
          res_x1   <= x1;
          res_x2   <= x2;
          s1_m     <= f_mag_max;
          s1_fault <= f_nonfin | fp_nonfinite(x0) | fp_nonfinite(x1) | fp_nonfinite(x2);
          if (iter_cnt != 7'd64) iter_cnt <= iter_cnt + 7'd1;
        end
        if (s1_vld) res_norm <= {1'b0, s1_m};
        if (decide) begin
          status <= dec_status;
          done   <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == S_RUN);
  assign halt = done;

endmodule

// File: tb/tb_nr_convergence_monitor.sv
// Directed bench for nr_convergence_monitor with hand-computed expectations.
module tb_nr_convergence_monitor;

  logic        clk = 1'b0;
  logic        rst, start, f_stb;
  logic [5:0]  num_cycles;
  logic [31:0] tol, x0, x1, x2, f0, f1, f2;
  logic        busy, done, halt;
  logic [1:0]  status;
  logic [6:0]  iter_cnt;
  logic [31:0] res_norm, res_x0, res_x1, res_x2;

  int n_cmp = 0;
  int n_mis = 0;

  nr_convergence_monitor #(.W(32), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .tol(tol),
    .f_stb(f_stb), .x0(x0), .x1(x1), .x2(x2), .f0(f0), .f1(f1), .f2(f2),
    .busy(busy), .done(done), .halt(halt), .status(status), .iter_cnt(iter_cnt),
    .res_norm(res_norm), .res_x0(res_x0), .res_x1(res_x1), .res_x2(res_x2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_strobe(input logic [31:0] a, b, c, p, q, r);
    f_stb = 1'b1;
    x0 = a; x1 = b; x2 = c;
    f0 = p; f1 = q; f2 = r;
  endtask

  task automatic do_start(input logic [31:0] t, input logic [5:0] n);
    start = 1'b1; tol = t; num_cycles = n;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_cleared(input string tag, input logic exp_busy);
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_halt"}, 32'(halt), 32'd0);
    chk({tag, "_status"}, 32'(status), 32'd0);
    chk({tag, "_iter"}, 32'(iter_cnt), 32'd0);
    chk({tag, "_norm"}, res_norm, 32'd0);
    chk({tag, "_x0"}, res_x0, 32'd0);
    chk({tag, "_x1"}, res_x1, 32'd0);
    chk({tag, "_x2"}, res_x2, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; f_stb = 1'b0; num_cycles = '0; tol = '0;
    x0 = '0; x1 = '0; x2 = '0; f0 = '0; f1 = '0; f2 = '0;
    tick(); tick();
    rst = 1'b0;
    chk_cleared("reset", 1'b0);

    // strobe while idle is ignored
    set_strobe(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 32'h0);
    tick(); f_stb = 1'b0; tick();
    chk_cleared("idle_strobe", 1'b0);

    // converged run
    do_start(32'h358637BD, 6'd5);
    chk("conv_busy", 32'(busy), 32'd1);
    set_strobe(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3F000000, 32'hBF800000);
    tick(); f_stb = 1'b0; tick();
    chk("conv_s1_done", 32'(done), 32'd0);
    chk("conv_s1_norm", res_norm, 32'h3F800000);
    chk("conv_s1_iter", 32'(iter_cnt), 32'd1);
    set_strobe(32'h3F800001, 32'h40000001, 32'h40400001, 32'h33D6BF95, 32'hB3D6BF95, 32'h0);
    tick();
    chk("conv_s2_early", 32'(done), 32'd0);
    set_strobe(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    tick(); f_stb = 1'b0;
    chk("conv_done", 32'(done), 32'd1);
    chk("conv_halt", 32'(halt), 32'd1);
    chk("conv_busy_off", 32'(busy), 32'd0);
    chk("conv_status", 32'(status), 32'd1);
    chk("conv_iter", 32'(iter_cnt), 32'd2);
    chk("conv_norm", res_norm, 32'h33D6BF95);
    chk("conv_x0", res_x0, 32'h3F800001);
    chk("conv_x1", res_x1, 32'h40000001);
    chk("conv_x2", res_x2, 32'h40400001);
    tick();
    chk("conv_hold_x0", res_x0, 32'h3F800001);

    // iteration limit, back-to-back strobes; also a start issued while in DONE
    do_start(32'h358637BD, 6'd3);
    chk_cleared("restart", 1'b1);
    for (int k = 1; k <= 3; k++) begin
      set_strobe(32'(k), 32'(k + 10), 32'(k + 20), 32'h3F800000, 32'h3F800000, 32'h3F800000);
      tick();
    end
    f_stb = 1'b0;
    chk("max_early", 32'(done), 32'd0);
    tick();
    chk("max_done", 32'(done), 32'd1);
    chk("max_status", 32'(status), 32'd2);
    chk("max_iter", 32'(iter_cnt), 32'd3);
    set_strobe(32'h99, 32'h99, 32'h99, 32'h0, 32'h0, 32'h0);
    tick(); f_stb = 1'b0; tick();
    chk("max_4th_iter", 32'(iter_cnt), 32'd3);
    chk("max_4th_status", 32'(status), 32'd2);
    chk("max_4th_x0", res_x0, 32'd3);
    chk("max_4th_norm", res_norm, 32'h3F800000);

    // NaN residual beats a huge tolerance
    do_start(32'h7F7FFFFF, 6'd5);
    set_strobe(32'h0, 32'h0, 32'h0, 32'h0, 32'h7FC00000, 32'h0);
    tick(); f_stb = 1'b0; tick();
    chk("fault_nan_done", 32'(done), 32'd1);
    chk("fault_nan_status", 32'(status), 32'd3);
    // Inf in the iterate
    do_start(32'h7F7FFFFF, 6'd5);
    set_strobe(32'h0, 32'h0, 32'h7F800000, 32'h0, 32'h0, 32'h0);
    tick(); f_stb = 1'b0; tick();
    chk("fault_inf_status", 32'(status), 32'd3);
    chk("fault_inf_x2", res_x2, 32'h7F800000);

    // num_cycles = 0 means 64
    do_start(32'h358637BD, 6'd0);
    for (int k = 0; k < 63; k++) begin
      set_strobe(32'(k), 32'h0, 32'h0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
      tick();
    end
    f_stb = 1'b0;
    tick();
    chk("lim64_63_done", 32'(done), 32'd0);
    chk("lim64_63_iter", 32'(iter_cnt), 32'd63);
    set_strobe(32'h40, 32'h0, 32'h0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tick(); f_stb = 1'b0; tick();
    chk("lim64_done", 32'(done), 32'd1);
    chk("lim64_status", 32'(status), 32'd2);
    chk("lim64_iter", 32'(iter_cnt), 32'd64);

    // start coincident with a strobe: strobe discarded
    set_strobe(32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0);
    do_start(32'h358637BD, 6'd5);
    f_stb = 1'b0;
    tick();
    chk_cleared("start_stb", 1'b1);

    // reset mid-run aborts; later strobes ignored
    set_strobe(32'h5, 32'h5, 32'h5, 32'h3F800000, 32'h0, 32'h0);
    tick(); f_stb = 1'b0; tick();
    chk("midrun_iter", 32'(iter_cnt), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_cleared("midrun_rst", 1'b0);
    set_strobe(32'h7, 32'h7, 32'h7, 32'h0, 32'h0, 32'h0);
    tick(); f_stb = 1'b0; tick();
    chk_cleared("post_rst", 1'b0);

    // -0 tolerance with signed zeros converges
    do_start(32'h80000000, 6'd5);
    set_strobe(32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000, 32'h80000000);
    tick(); f_stb = 1'b0; tick();
    chk("negzero_done", 32'(done), 32'd1);
    chk("negzero_status", 32'(status), 32'd1);
    chk("negzero_norm", res_norm, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
